// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC angle front end and its core.
package cordic_pkg;

  localparam int unsigned PHASE_W = 10;
  localparam int unsigned ANG_W   = PHASE_W - 2;
  localparam int unsigned ITER    = 8;
  localparam int unsigned SETTLE  = 1;

  // Encodings kept identical to the legacy 2-bit state register.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic swap;
    logic neg_cos;
    logic neg_sin;
  } quad_flags_t;

  function automatic quad_flags_t quad_flags(input logic [1:0] q);
    quad_flags_t f;
    case (q)
      2'd0:    f = '{swap: 1'b0, neg_cos: 1'b0, neg_sin: 1'b0};
      2'd1:    f = '{swap: 1'b1, neg_cos: 1'b1, neg_sin: 1'b0};
      2'd2:    f = '{swap: 1'b0, neg_cos: 1'b1, neg_sin: 1'b1};
      default: f = '{swap: 1'b1, neg_cos: 1'b0, neg_sin: 1'b1};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/cordic_angle_frontend_if.sv
// Phase-word valid/ready handshake into the CORDIC angle front end.
interface cordic_angle_frontend_if #(
  parameter int unsigned PHASE_W = cordic_pkg::PHASE_W
);
  logic               IN_VALID;
  logic               IN_READY;
  logic [PHASE_W-1:0] IN_PHASE;

  modport master (output IN_VALID, output IN_PHASE, input IN_READY);
  modport slave  (input IN_VALID, input IN_PHASE, output IN_READY);
endinterface

// File: rtl/cordic_quadrant_map.sv
// Splits a full-circle phase into quadrant, first-quadrant angle and fix-up flags.
module cordic_quadrant_map #(
  parameter int unsigned PHASE_W = cordic_pkg::PHASE_W,
  parameter int unsigned ANG_W   = cordic_pkg::ANG_W
) (
  input  logic [PHASE_W-1:0]     phase,
  output logic [ANG_W-1:0]       angle,
  output logic [1:0]             quad,
  output cordic_pkg::quad_flags_t flags
);
  import cordic_pkg::*;

  always_comb begin
    quad  = phase[PHASE_W-1 -: 2];
    angle = phase[ANG_W-1:0];
    flags = quad_flags(quad);
  end
endmodule

// File: rtl/cordic_angle_frontend.sv
// Accepts a phase word, drives the CORDIC core start pulse and angle, times the run.
module cordic_angle_frontend #(
  parameter int unsigned PHASE_W = cordic_pkg::PHASE_W,
  parameter int unsigned ANG_W   = cordic_pkg::ANG_W,
  parameter int unsigned ITER    = cordic_pkg::ITER,
  parameter int unsigned SETTLE  = cordic_pkg::SETTLE
) (
  input  logic                     CLK,
  input  logic                     RESET,
  cordic_angle_frontend_if.slave   in_bus,
  output logic [ANG_W-1:0]         CORE_ANGLE,
  output logic                     CORE_RESET_PULSE,
  output logic [1:0]               QUAD,
  output logic                     SWAP,
  output logic                     NEG_COS,
  output logic                     NEG_SIN,
  output logic                     BUSY,
  output logic                     DONE
);
  import cordic_pkg::*;

  localparam int unsigned     RUN_LEN  = ITER + SETTLE;
  localparam int unsigned     CNT_W    = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);

  state_e            state;
  state_e            state_nxt;
  logic [CNT_W-1:0]  count;
  logic              accept;
  logic [ANG_W-1:0]  map_angle;
  logic [1:0]        map_quad;
  quad_flags_t       map_flags;

  cordic_quadrant_map #(
    .PHASE_W (PHASE_W),
    .ANG_W   (ANG_W)
  ) u_map (
    .phase (in_bus.IN_PHASE),
    .angle (map_angle),
    .quad  (map_quad),
    .flags (map_flags)
  );

  // Ready is gated by RESET so a word is never taken while the block is held.
  always_comb begin
    in_bus.IN_READY = RESET && (state == ST_IDLE);
    accept          = in_bus.IN_READY && in_bus.IN_VALID;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_START;
      ST_START: state_nxt = ST_RUN;
      ST_RUN:   if (count == CNT_LAST) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state            <= ST_IDLE;
      count            <= '0;
      CORE_ANGLE       <= '0;
      CORE_RESET_PULSE <= 1'b0;
      QUAD             <= '0;
      SWAP             <= 1'b0;
      NEG_COS          <= 1'b0;
      NEG_SIN          <= 1'b0;
      BUSY             <= 1'b0;
      DONE             <= 1'b0;
    end else begin
      state            <= state_nxt;
      CORE_RESET_PULSE <= (state_nxt != ST_START);
      BUSY             <= (state_nxt != ST_IDLE);
      DONE             <= (state_nxt == ST_DONE);

      if ((state == ST_RUN) && (state_nxt == ST_RUN)) begin
        if (count != CNT_LAST) count <= count + 1'b1;
      end else begin
        count <= '0;
      end

      if (accept) begin
        CORE_ANGLE <= map_angle;
        QUAD       <= map_quad;
        SWAP       <= map_flags.swap;
        NEG_COS    <= map_flags.neg_cos;
        NEG_SIN    <= map_flags.neg_sin;
      end
    end
  end
endmodule

// File: tb/tb_cordic_angle_frontend.sv
// Directed-vector bench for cordic_angle_frontend with hand-computed expectations.
module tb_cordic_angle_frontend;

  logic       CLK;
  logic       RESET;
  logic [7:0] CORE_ANGLE;
  logic       CORE_RESET_PULSE;
  logic [1:0] QUAD;
  logic       SWAP, NEG_COS, NEG_SIN, BUSY, DONE;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned done_cnt = 0;

  cordic_angle_frontend_if #(.PHASE_W(10)) bus ();

  cordic_angle_frontend #(
    .PHASE_W (10),
    .ANG_W   (8),
    .ITER    (8),
    .SETTLE  (1)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .in_bus           (bus.slave),
    .CORE_ANGLE       (CORE_ANGLE),
    .CORE_RESET_PULSE (CORE_RESET_PULSE),
    .QUAD             (QUAD),
    .SWAP             (SWAP),
    .NEG_COS          (NEG_COS),
    .NEG_SIN          (NEG_SIN),
    .BUSY             (BUSY),
    .DONE             (DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (DONE === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [2:0] flags_now();
    return {SWAP, NEG_COS, NEG_SIN};
  endfunction

  task automatic run_word(input logic [9:0] ph, input logic [7:0] ang,
                          input logic [1:0] q, input logic [2:0] fl);
    int lat;
    int pulse_low;
    check("ready_before", bus.IN_READY, 1);
    bus.IN_VALID = 1'b1;
    bus.IN_PHASE = ph;
    tick();
    bus.IN_VALID = 1'b0;
    bus.IN_PHASE = ~ph;
    check("start_pulse", CORE_RESET_PULSE, 0);
    check("start_busy", BUSY, 1);
    check("start_ready", bus.IN_READY, 0);
    check("start_angle", CORE_ANGLE, ang);
    check("start_quad", QUAD, q);
    check("start_flags", flags_now(), fl);
    tick();
    check("run_pulse", CORE_RESET_PULSE, 1);
    lat = 1;
    pulse_low = 0;
    while (DONE !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      if (CORE_RESET_PULSE !== 1'b1) pulse_low++;
    end
    check("latency", lat, 10);
    check("run_pulse_low", pulse_low, 0);
    check("done_angle", CORE_ANGLE, ang);
    check("done_quad", QUAD, q);
    check("done_flags", flags_now(), fl);
    tick();
    check("done_drop", DONE, 0);
    check("ready_after", bus.IN_READY, 1);
    check("busy_after", BUSY, 0);
    check("hold_angle", CORE_ANGLE, ang);
  endtask

  logic [9:0] sw_ph  [4] = '{10'h000, 10'h0FF, 10'h2A0, 10'h3FF};
  logic [7:0] sw_ang [4] = '{8'h00, 8'hFF, 8'hA0, 8'hFF};
  logic [1:0] sw_q   [4] = '{2'd0, 2'd0, 2'd2, 2'd3};
  logic [2:0] sw_fl  [4] = '{3'b000, 3'b000, 3'b011, 3'b101};

  initial begin
    int n;
    int low;
    int moved;
    int done_at;
    int unsigned base;
    int unsigned acc_cyc;
    int unsigned prev_acc;

    RESET        = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN_PHASE = '0;
    repeat (3) tick();
    check("rst_ready", bus.IN_READY, 0);
    check("rst_pulse", CORE_RESET_PULSE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_angle", CORE_ANGLE, 0);
    check("rst_quad", QUAD, 0);
    check("rst_flags", flags_now(), 0);
    RESET = 1'b1;
    tick();
    check("idle_pulse", CORE_RESET_PULSE, 1);
    check("idle_ready", bus.IN_READY, 1);

    run_word(10'h040, 8'd64,  2'd0, 3'b000);
    run_word(10'h180, 8'd128, 2'd1, 3'b110);

    // Overlap: valid held with a changing phase through the whole run.
    bus.IN_VALID = 1'b1;
    bus.IN_PHASE = 10'h100;
    tick();
    check("ovl_start_pulse", CORE_RESET_PULSE, 0);
    check("ovl_angle_r0", CORE_ANGLE, 0);
    check("ovl_quad", QUAD, 1);
    check("ovl_flags", flags_now(), 3'b110);
    low = 0; moved = 0; done_at = 0;
    for (int i = 1; i <= 11; i++) begin
      bus.IN_PHASE = 10'(10'h155 + i * 37);
      tick();
      if (CORE_RESET_PULSE !== 1'b1) low++;
      if (CORE_ANGLE !== 8'd0 || QUAD !== 2'd1) moved++;
      if (i <= 10 && bus.IN_READY !== 1'b0) moved++;
      if (DONE === 1'b1) done_at = i;
    end
    check("ovl_pulse_low", low, 0);
    check("ovl_hold", moved, 0);
    check("ovl_done_at", done_at, 10);
    check("ovl_ready_idle", bus.IN_READY, 1);
    bus.IN_PHASE = 10'h3FF;
    tick();
    check("top_pulse", CORE_RESET_PULSE, 0);
    check("top_angle", CORE_ANGLE, 8'd255);
    check("top_quad", QUAD, 3);
    check("top_flags", flags_now(), 3'b101);
    bus.IN_VALID = 1'b0;
    n = 0;
    while (BUSY !== 1'b0 && n < 20) begin tick(); n++; end
    check("top_drain", BUSY, 0);

    // Reset while RUN count is 4.
    bus.IN_VALID = 1'b1;
    bus.IN_PHASE = 10'h0C0;
    tick();
    bus.IN_VALID = 1'b0;
    repeat (5) tick();
    check("mid_busy_pre", BUSY, 1);
    RESET = 1'b0;
    bus.IN_VALID = 1'b1;
    base = done_cnt;
    tick();
    check("mid_busy", BUSY, 0);
    check("mid_pulse", CORE_RESET_PULSE, 0);
    check("mid_done", DONE, 0);
    check("mid_flags", flags_now(), 0);
    check("mid_angle", CORE_ANGLE, 0);
    check("mid_ready", bus.IN_READY, 0);
    repeat (2) tick();
    check("mid_no_accept", BUSY, 0);
    bus.IN_VALID = 1'b0;
    RESET = 1'b1;
    repeat (12) tick();
    check("mid_no_done", done_cnt - base, 0);
    run_word(10'h2A0, 8'hA0, 2'd2, 3'b011);

    // Streaming with valid tied high.
    base = done_cnt;
    prev_acc = 0;
    bus.IN_VALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.IN_PHASE = sw_ph[k];
      n = 0;
      do begin tick(); n++; end while (CORE_RESET_PULSE !== 1'b0 && n < 20);
      acc_cyc = cyc;
      if (k > 0) check("stream_gap", acc_cyc - prev_acc, 12);
      prev_acc = acc_cyc;
      n = 0;
      while (DONE !== 1'b1 && n < 20) begin tick(); n++; end
      check("stream_lat", cyc - acc_cyc, 10);
      check("stream_angle", CORE_ANGLE, sw_ang[k]);
      check("stream_quad", QUAD, sw_q[k]);
      check("stream_flags", flags_now(), sw_fl[k]);
    end
    bus.IN_VALID = 1'b0;
    repeat (2) tick();
    check("stream_dones", done_cnt - base, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
